// File: rtl/stack_host_pkg.sv
// -----------------------------------------------------------------------------
// stack_host_pkg
// Shared types for the stack-device host driver: FSM state encoding,
// command op codes and response error codes.
// -----------------------------------------------------------------------------
package stack_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_OVF = 2'b01,
    ERR_UNF = 2'b10,
    ERR_TMO = 2'b11
  } err_t;

endpackage

// File: rtl/stack_host_if.sv
// -----------------------------------------------------------------------------
// stack_host_if
// Bundles the command/response handshake and the stack-device pin set.
//   master : the host driver (consumes commands, drives device strobes/bus)
//   slave  : the command source plus the device (bench side)
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_data   command request (valid/ready)
//   rsp_valid/rsp_data/rsp_err            one-cycle response strobe
//   count                                 shadow occupancy
//   dev_push/dev_pop/dev_done             device strobes and idle flag
//   dev_data_o/dev_data_oe/dev_data_i     split view of the bidirectional bus
// -----------------------------------------------------------------------------
interface stack_host_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_err;
  logic [CNT_W-1:0]  count;
  logic              dev_push;
  logic              dev_pop;
  logic              dev_done;
  logic [DATA_W-1:0] dev_data_o;
  logic              dev_data_oe;
  logic [DATA_W-1:0] dev_data_i;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, dev_done, dev_data_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, count,
           dev_push, dev_pop, dev_data_o, dev_data_oe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, dev_done, dev_data_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, count,
           dev_push, dev_pop, dev_data_o, dev_data_oe
  );
endinterface

// File: rtl/stack_host_timeout.sv
// -----------------------------------------------------------------------------
// stack_host_timeout
// Wait-state watchdog. Cleared by load, counts while en is high, and raises
// expired once LIMIT cycles have been spent since the last load (the count
// saturates there). Only instantiated when STACK_HOST_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        clear the count (wins over en)
//   en          advance the count
//   expired     LIMIT cycles elapsed since load
// -----------------------------------------------------------------------------
module stack_host_timeout #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  // The first waiting cycle sees cnt=0, so the LIMIT-th sees LIMIT-1.
  assign expired = (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/stack_host_driver.sv
// -----------------------------------------------------------------------------
// stack_host_driver
// Initiator for the stack-device pin protocol. Takes push/pop commands on a
// valid/ready handshake, sequences push/pop strobes against the device's done
// flag, owns the data bus during pushes and returns a one-cycle response.
// A shadow occupancy count rejects overflow/underflow without touching pins.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         stack_host_if.master (command, response, count, device pins)
// Optional build macro:
//   STACK_HOST_TIMEOUT_EN  bound each WAIT_* state to TIMEOUT_CYC cycles and
//                          answer ERR_TMO on expiry; without it waits are unbounded.
// -----------------------------------------------------------------------------
module stack_host_driver
  import stack_host_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  stack_host_if.master bus
);
  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  if (DEPTH < 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("stack_host_driver: DEPTH and TIMEOUT_CYC must be at least 1");
  end

  state_t            state_q,     state_d;
  op_t               op_q,        op_d;
  logic              dev_push_q,  dev_push_d;
  logic              dev_pop_q,   dev_pop_d;
  logic              data_oe_q,   data_oe_d;
  logic [DATA_W-1:0] data_o_q,    data_o_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  err_t              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic              tmo_expired;

`ifdef STACK_HOST_TIMEOUT_EN
  logic tmo_load;
  logic tmo_en;

  // Restart the watchdog on every entry into a wait state.
  assign tmo_load = ((state_d == ST_WAIT_ACK)  && (state_q != ST_WAIT_ACK)) ||
                    ((state_d == ST_WAIT_DONE) && (state_q != ST_WAIT_DONE));
  assign tmo_en   = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);

  stack_host_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.count       = count_q;
  assign bus.dev_push    = dev_push_q;
  assign bus.dev_pop     = dev_pop_q;
  assign bus.dev_data_o  = data_o_q;
  assign bus.dev_data_oe = data_oe_q;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    dev_push_d  = dev_push_q;
    dev_pop_d   = dev_pop_q;
    data_oe_d   = data_oe_q;
    data_o_d    = data_o_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    count_d     = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d = op_t'(bus.cmd_op);
          if ((bus.cmd_op == OP_PUSH) && (count_q == COUNT_FULL)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_OVF;
            rsp_data_d  = '0;
          end else if ((bus.cmd_op == OP_POP) && (count_q == '0)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_UNF;
            rsp_data_d  = '0;
          end else if (bus.cmd_op == OP_PUSH) begin
            // Push data is latched straight onto the bus register.
            state_d    = ST_STROBE;
            dev_push_d = 1'b1;
            data_oe_d  = 1'b1;
            data_o_d   = bus.cmd_data;
          end else begin
            state_d   = ST_STROBE;
            dev_pop_d = 1'b1;
          end
        end
      end

      ST_STROBE: state_d = ST_WAIT_ACK;

      ST_WAIT_ACK: begin
        // Device acknowledges by dropping done; the strobe is held until then.
        if (!bus.dev_done) begin
          state_d    = ST_WAIT_DONE;
          dev_push_d = 1'b0;
          dev_pop_d  = 1'b0;
        end else if (tmo_expired) begin
          state_d     = ST_RESP;
          dev_push_d  = 1'b0;
          dev_pop_d   = 1'b0;
          data_oe_d   = 1'b0;
          data_o_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
          rsp_data_d  = '0;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.dev_done) begin
          state_d = ST_SETTLE;
        end else if (tmo_expired) begin
          state_d     = ST_RESP;
          data_oe_d   = 1'b0;
          data_o_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
          rsp_data_d  = '0;
        end
      end

      ST_SETTLE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ERR_OK;
        if (op_q == OP_POP) begin
          rsp_data_d = bus.dev_data_i;
          count_d    = count_q - CNT_W'(1);
        end else begin
          rsp_data_d = '0;
          data_oe_d  = 1'b0;
          data_o_d   = '0;
          count_d    = count_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d    = ST_IDLE;
        rsp_data_d = '0;
        rsp_err_d  = ERR_OK;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      dev_push_q  <= 1'b0;
      dev_pop_q   <= 1'b0;
      data_oe_q   <= 1'b0;
      data_o_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      dev_push_q  <= dev_push_d;
      dev_pop_q   <= dev_pop_d;
      data_oe_q   <= data_oe_d;
      data_o_q    <= data_o_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_stack_host_driver.sv
// -----------------------------------------------------------------------------
// tb_stack_host_driver
// Drives directed push/pop sequences into stack_host_driver against a
// behavioural stack device (16-entry memory, programmable ack/busy delays,
// optional never-acknowledge mode). A monitor keeps a queue model of the
// stack and checks every response, the count and the pin rules each cycle;
// the stimulus adds literal expectations for the directed cases.
// -----------------------------------------------------------------------------
module tb_stack_host_driver;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TMO    = 15;
  localparam int CNT_W  = 5;

  localparam logic PUSH = 1'b0;
  localparam logic POP  = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  stack_host_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  stack_host_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- device
  int   ack_delay  = 1;   // edges of strobe seen before done drops
  int   busy_delay = 1;   // cycles done stays low
  bit   never_ack  = 1'b0;
  logic [DATA_W-1:0] dev_mem [DEPTH];
  int   sp;
  int   dcnt;
  bit   dev_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_busy       <= 1'b0;
      dcnt           <= 0;
      sp             <= 0;
      bus.dev_done   <= 1'b1;
      bus.dev_data_i <= '0;
    end else if (!dev_busy) begin
      if ((bus.dev_push || bus.dev_pop) && !never_ack) begin
        if (dcnt + 1 >= ack_delay) begin
          bus.dev_done <= 1'b0;
          dev_busy     <= 1'b1;
          dcnt         <= 1;
          if (bus.dev_push) begin
            if (sp < DEPTH) begin
              dev_mem[sp] <= bus.dev_data_o;
              sp          <= sp + 1;
            end
          end else if (sp > 0) begin
            bus.dev_data_i <= dev_mem[sp-1];
            sp             <= sp - 1;
          end
        end else begin
          dcnt <= dcnt + 1;
        end
      end else begin
        dcnt <= 0;
      end
    end else if (dcnt >= busy_delay) begin
      bus.dev_done <= 1'b1;
      dev_busy     <= 1'b0;
      dcnt         <= 0;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  // ---------------------------------------------------------------- monitor
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        err;
    int                lat;
    int                strobes;
    bit                dev_op;
  } exp_t;

  logic [DATA_W-1:0] model[$];
  exp_t              exp_q[$];
  int                cyc = 0;
  int                acc_cyc;
  int                strobe_cyc;
  bit                cur_push;
  logic [DATA_W-1:0] cur_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model.delete();
      exp_q.delete();
      strobe_cyc = 0;
    end else begin
      check("strobe_overlap", 32'(bus.dev_push && bus.dev_pop), 0);
      if (bus.dev_data_oe) begin
        check("oe_only_push", 32'(cur_push), 1);
        check("bus_data", 32'(bus.dev_data_o), 32'(cur_data));
      end
      if (bus.dev_push || bus.dev_pop) strobe_cyc++;
      if (bus.cmd_ready && exp_q.size() == 0)
        check("idle_count", 32'(bus.count), 32'(model.size()));

      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_count", 32'(bus.count), 32'(model.size()));
          check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
          check("rsp_strobe_cycles", 32'(strobe_cyc), 32'(e.strobes));
          check("rsp_pins_idle", 32'({bus.dev_push, bus.dev_pop, bus.dev_data_oe}), 0);
          if (e.dev_op) check("rsp_done_high", 32'(bus.dev_done), 1);
        end
      end

      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc    = cyc;
        strobe_cyc = 0;
        cur_push   = (bus.cmd_op == PUSH);
        cur_data   = bus.cmd_data;
        e.data     = '0;
        e.dev_op   = 1'b0;
        e.strobes  = 0;
        e.lat      = 1;
        if (bus.cmd_op == PUSH && model.size() >= DEPTH) begin
          e.err = 2'b01;
        end else if (bus.cmd_op == POP && model.size() == 0) begin
          e.err = 2'b10;
        end else if (never_ack) begin
          e.err     = 2'b11;
          e.dev_op  = 1'b1;
          e.lat     = TMO + 2;
          e.strobes = TMO + 1;
        end else begin
          e.err     = 2'b00;
          e.dev_op  = 1'b1;
          e.lat     = ack_delay + busy_delay + 3;
          e.strobes = ack_delay + 1;
          if (bus.cmd_op == PUSH) model.push_back(bus.cmd_data);
          else e.data = model.pop_back();
        end
        exp_q.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic start_cmd(input logic op, input logic [DATA_W-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    while (1) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
  endtask

  task automatic wait_rsp(output logic [DATA_W-1:0] rd, output logic [1:0] re, output int lat);
    lat = 1;
    rd  = '0;
    re  = '0;
    while (1) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rd = bus.rsp_data;
        re = bus.rsp_err;
        break;
      end
      lat++;
      if (lat > 300) begin
        check("rsp_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic do_cmd(input logic op, input logic [DATA_W-1:0] d,
                        output logic [DATA_W-1:0] rd, output logic [1:0] re, output int lat);
    start_cmd(op, d);
    wait_rsp(rd, re, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic [1:0]        re;
    int                lat;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = PUSH;
    bus.cmd_data  = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.count,
                                bus.dev_push, bus.dev_pop, bus.dev_data_o, bus.dev_data_oe}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(bus.cmd_ready), 1);

    // Pop on an empty stack is rejected next cycle, no pop strobe
    do_cmd(POP, 8'h00, rd, re, lat);
    check("t2_err", 32'(re), 32'h2);
    check("t2_lat", 32'(lat), 1);
    check("t2_data", 32'(rd), 0);

    // Push then pop one value
    do_cmd(PUSH, 8'hA5, rd, re, lat);
    check("t1_push_err", 32'(re), 0);
    check("t1_push_lat", 32'(lat), 5);
    check("t1_count1", 32'(bus.count), 1);
    do_cmd(POP, 8'h00, rd, re, lat);
    check("t1_pop_data", 32'(rd), 32'hA5);
    check("t1_pop_err", 32'(re), 0);
    check("t1_count0", 32'(bus.count), 0);

    // Fill, overflow, drain in LIFO order
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(PUSH, 8'(i), rd, re, lat);
      check("t3_push_err", 32'(re), 0);
    end
    check("t3_full_count", 32'(bus.count), 16);
    do_cmd(PUSH, 8'hFF, rd, re, lat);
    check("t3_ovf_err", 32'(re), 32'h1);
    check("t3_ovf_lat", 32'(lat), 1);
    check("t3_ovf_count", 32'(bus.count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(POP, 8'h00, rd, re, lat);
      check("t3_pop_data", 32'(rd), 32'(15 - i));
    end
    check("t3_empty_count", 32'(bus.count), 0);

    // Slow device: strobe held 10 edges, done low 3 cycles
    ack_delay  = 10;
    busy_delay = 3;
    do_cmd(PUSH, 8'h5A, rd, re, lat);
    check("t4_push_lat", 32'(lat), 16);
    check("t4_push_err", 32'(re), 0);
    do_cmd(POP, 8'h00, rd, re, lat);
    check("t4_pop_data", 32'(rd), 32'h5A);
    check("t4_pop_lat", 32'(lat), 16);
    ack_delay  = 1;
    busy_delay = 1;

`ifdef STACK_HOST_TIMEOUT_EN
    // Device never acknowledges: timeout after 15 cycles in WAIT_ACK
    never_ack = 1'b1;
    do_cmd(PUSH, 8'h3C, rd, re, lat);
    check("t5_err", 32'(re), 32'h3);
    check("t5_lat", 32'(lat), 17);
    check("t5_count", 32'(bus.count), 0);
    check("t5_pins_idle", 32'({bus.dev_push, bus.dev_pop, bus.dev_data_oe}), 0);
    never_ack = 1'b0;
`endif

    // Reset in the middle of a push (WAIT_DONE)
    do_cmd(PUSH, 8'h11, rd, re, lat);
    check("t6_count1", 32'(bus.count), 1);
    busy_delay = 6;
    start_cmd(PUSH, 8'h77);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t6_mid_oe", 32'(bus.dev_data_oe), 1);
    check("t6_mid_done", 32'(bus.dev_done), 0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.count,
                                   bus.dev_push, bus.dev_pop, bus.dev_data_o, bus.dev_data_oe}), 0);
    busy_delay = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_rsp", 32'(bus.rsp_valid), 0);
    end
    do_cmd(POP, 8'h00, rd, re, lat);
    check("t6_pop_after_reset", 32'(re), 32'h2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
